// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbitration slice: state encoding,
// byte width and the rotate-priority one-hot selector.
package uart_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_HOLD
    } arb_state_t;

    // First set bit of req scanning upward from ptr, wrapping at n (n <= MAX_REQ).
    function automatic logic [MAX_REQ-1:0] rr_onehot(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input logic [3:0]         n
    );
        logic [MAX_REQ-1:0] sel;
        logic [3:0]         idx;
        logic               found;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= n) idx = idx - n;
            if (!found && (4'(k) < n) && req[idx[2:0]]) begin
                sel[idx[2:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle around the UART TX arbiter.
interface uart_tx_arbiter_if import uart_pkg::*; #(
    parameter int unsigned NREQ = 3
);

    logic [NREQ-1:0]        req;
    logic [NREQ*BYTE_W-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        grant;
    logic [BYTE_W-1:0]      tx_data;
    logic                   tx_start;
    logic                   tx_clear;
    logic                   tx_busy;
    logic                   arb_idle;
    logic                   timeout_evt;

    modport master (
        input  req, req_data, req_last, tx_clear, tx_busy,
        output ack, grant, tx_data, tx_start, arb_idle, timeout_evt
    );

    modport slave (
        output req, req_data, req_last, tx_clear, tx_busy,
        input  ack, grant, tx_data, tx_start, arb_idle, timeout_evt
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: one-hot winner and its index, scanning
// from ptr upward with wrap.
module uart_rr_pick import uart_pkg::*; #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] sel;

    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req;
        sel                = rr_onehot(req_ext, 3'(ptr), 4'(NREQ));
        onehot             = sel[NREQ-1:0];
        idx                = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (sel[i]) idx = PW'(i);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NREQ
// requesters, with per-message grant locking and a lock idle timeout.
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int unsigned NREQ         = 3,
    parameter int unsigned LOCK_TIMEOUT = 1023,
    parameter int unsigned GUARD        = 2
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.master  bus
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

    localparam logic [TW-1:0] TO_MAX  = TW'(LOCK_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [GW-1:0] G_MAX   = GW'(GUARD);

    arb_state_t        state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     nxt_ptr;
    logic              lock;
    logic [GW-1:0]     guard_cnt;
    logic [TW-1:0]     to_cnt;
    logic [NREQ-1:0]   pick_oh;
    logic [PW-1:0]     pick_idx;

    logic [NREQ-1:0]   ack_q;
    logic [NREQ-1:0]   grant_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic              tx_start_q;
    logic              idle_q;
    logic              timeout_q;

    uart_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign nxt_ptr = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            owner      <= '0;
            lock       <= 1'b0;
            guard_cnt  <= '0;
            to_cnt     <= '0;
            ack_q      <= '0;
            grant_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            idle_q     <= 1'b1;
            timeout_q  <= 1'b0;
        end else begin
            ack_q     <= '0;
            timeout_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        grant_q <= pick_oh;
                        owner   <= pick_idx;
                        idle_q  <= 1'b0;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_data_q  <= bus.req_data[owner*BYTE_W +: BYTE_W];
                    lock       <= ~bus.req_last[owner];
                    tx_start_q <= 1'b1;
                    state      <= ST_START;
                end
                ST_START: begin
                    if (bus.tx_clear) begin
                        ack_q      <= grant_q;
                        tx_start_q <= 1'b0;
                        guard_cnt  <= '0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (guard_cnt != G_MAX) begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end else if (!bus.tx_busy) begin
                        if (lock) begin
                            to_cnt <= '0;
                            state  <= ST_HOLD;
                        end else begin
                            ptr     <= nxt_ptr;
                            grant_q <= '0;
                            idle_q  <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    // Only the lock owner may continue; everyone else waits.
                    if (bus.req[owner]) begin
                        to_cnt <= '0;
                        state  <= ST_LOAD;
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt    <= TO_MAX;
                        timeout_q <= 1'b1;
                        lock      <= 1'b0;
                        ptr       <= nxt_ptr;
                        grant_q   <= '0;
                        idle_q    <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack         = ack_q;
    assign bus.grant       = grant_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.arb_idle    = idle_q;
    assign bus.timeout_evt = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester message queues with a
// round-robin/lock reference model and a randomised transmitter model.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int LT = 15;
    localparam int GD = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } byte_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(N)) arb();

    uart_tx_arbiter #(
        .NREQ         (N),
        .LOCK_TIMEOUT (LT),
        .GUARD        (GD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (arb)
    );

    byte_t q [N][$];
    int    m_ptr, m_lock;
    int    n_checks, n_fail;
    int    cyc, last_ack_cyc, to_gap, to_grant_at, to_idle_at;
    int    n_acks, n_timeouts;
    int    ack_order[$];
    int    clr_max, busy_max, clr_wait, busy_cnt;
    bit    hold_clear, clear_on_ack, inj_clear;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Next byte owner: the lock holder, else first non-empty queue from the pointer.
    function automatic int exp_owner();
        int i;
        if (m_lock >= 0) return m_lock;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (q[i].size() > 0) return i;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic refresh_req();
        for (int i = 0; i < N; i++) begin
            arb.req[i] = (q[i].size() > 0);
            if (q[i].size() > 0) begin
                arb.req_data[i*8 +: 8] = q[i][0].data;
                arb.req_last[i]        = q[i][0].last;
            end
        end
    endtask

    task automatic enqueue(input int i, input logic [7:0] d, input logic l);
        byte_t b;
        b.data = d;
        b.last = l;
        q[i].push_back(b);
    endtask

    task automatic step();
        int o, e;
        @(posedge clk);
        #1;
        cyc++;
        if (arb.ack != '0) begin
            o = oh2idx(arb.ack);
            e = exp_owner();
            check("ack_owner", o, e);
            n_acks++;
            ack_order.push_back(o);
            last_ack_cyc = cyc;
            if (e >= 0) begin
                check("ack_grant", int'(arb.grant), 1 << e);
                check("ack_data", int'(arb.tx_data), int'(q[e][0].data));
                if (q[e][0].last) begin
                    m_lock = -1;
                    m_ptr  = (e + 1) % N;
                end else begin
                    m_lock = e;
                end
                void'(q[e].pop_front());
                refresh_req();
            end
            if (clear_on_ack) begin
                inj_clear    = 1'b1;
                clear_on_ack = 1'b0;
            end
        end
        if (arb.timeout_evt) begin
            n_timeouts++;
            to_gap      = cyc - last_ack_cyc;
            to_grant_at = int'(arb.grant);
            to_idle_at  = int'(arb.arb_idle);
            check("timeout_locked", int'(m_lock >= 0), 1);
            if (m_lock >= 0) begin
                m_ptr  = (m_lock + 1) % N;
                m_lock = -1;
            end
        end
        // transmitter model: takes the byte after a random delay, then shifts
        arb.tx_clear = 1'b0;
        arb.tx_busy  = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        if (inj_clear) begin
            arb.tx_clear = 1'b1;
            inj_clear    = 1'b0;
        end else if (arb.tx_start && !hold_clear) begin
            if (clr_wait == 0) begin
                arb.tx_clear = 1'b1;
                clr_wait     = int'($urandom_range(clr_max));
                busy_cnt     = int'($urandom_range(busy_max));
            end else begin
                clr_wait--;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) q[i].delete();
        m_ptr  = 0;
        m_lock = -1;
        refresh_req();
        busy_cnt   = 0;
        clr_wait   = 0;
        hold_clear = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while (!(all_empty() && arb.arb_idle && m_lock < 0) && k < budget) begin
            step();
            k++;
        end
        check(tag, int'(k < budget), 1);
    endtask

    initial begin
        int exp_seq[$];
        int k, a0, total, nm, len;

        arb.req      = '0;
        arb.req_data = '0;
        arb.req_last = '0;
        arb.tx_clear = 1'b0;
        arb.tx_busy  = 1'b0;
        clr_max  = 0;
        busy_max = 0;
        m_lock   = -1;

        // reset values
        do_reset();
        check("rst_ack", int'(arb.ack), 0);
        check("rst_grant", int'(arb.grant), 0);
        check("rst_tx_data", int'(arb.tx_data), 0);
        check("rst_tx_start", int'(arb.tx_start), 0);
        check("rst_timeout", int'(arb.timeout_evt), 0);
        check("rst_idle", int'(arb.arb_idle), 1);

        // single request, one-cycle arbitration latency
        clr_max  = 0;
        busy_max = 3;
        enqueue(0, 8'h41, 1'b1);
        refresh_req();
        step();
        check("single_grant", int'(arb.grant), 1);
        check("single_busy_flag", int'(arb.arb_idle), 0);
        step();
        check("single_tx_data", int'(arb.tx_data), 8'h41);
        check("single_tx_start", int'(arb.tx_start), 1);
        step();
        check("single_ack", int'(arb.ack), 1);
        check("single_start_drop", int'(arb.tx_start), 0);
        wait_done(100, "single_done");
        check("single_grant_end", int'(arb.grant), 0);

        // contention, everyone unlocked
        do_reset();
        clr_max  = 2;
        busy_max = 4;
        for (int r = 0; r < 2; r++) begin
            enqueue(0, 8'h41, 1'b1);
            enqueue(1, 8'h42, 1'b1);
            enqueue(2, 8'h43, 1'b1);
        end
        refresh_req();
        ack_order.delete();
        wait_done(500, "cont_done");
        exp_seq = '{0, 1, 2, 0, 1, 2};
        check("cont_count", ack_order.size(), 6);
        for (int i = 0; i < 6 && i < ack_order.size(); i++) check("cont_order", ack_order[i], exp_seq[i]);

        // locked message against a continuous competitor
        do_reset();
        clr_max  = 3;
        busy_max = 3;
        enqueue(0, 8'h61, 1'b1);
        enqueue(0, 8'h62, 1'b1);
        enqueue(0, 8'h63, 1'b1);
        enqueue(0, 8'h64, 1'b1);
        enqueue(1, 8'h48, 1'b0);
        enqueue(1, 8'h49, 1'b0);
        enqueue(1, 8'h0A, 1'b1);
        refresh_req();
        ack_order.delete();
        wait_done(800, "lock_done");
        exp_seq = '{0, 1, 1, 1, 0, 0, 0};
        check("lock_count", ack_order.size(), 7);
        for (int i = 0; i < 7 && i < ack_order.size(); i++) check("lock_order", ack_order[i], exp_seq[i]);

        // lock timeout after the owner stops requesting
        do_reset();
        clr_max  = 1;
        busy_max = 0;
        ack_order.delete();
        enqueue(2, 8'h5A, 1'b0);
        refresh_req();
        a0 = n_acks;
        k  = 0;
        while (n_acks == a0 && k < 50) begin step(); k++; end
        check("to_first_ack", n_acks - a0, 1);
        enqueue(0, 8'h30, 1'b1);
        refresh_req();
        a0     = n_timeouts;
        to_gap = -1;
        wait_done(200, "to_done");
        check("to_count", n_timeouts - a0, 1);
        check("to_gap", to_gap, GD + 1 + LT);
        check("to_grant_zero", to_grant_at, 0);
        check("to_idle", to_idle_at, 1);
        check("to_order_n", ack_order.size(), 2);
        if (ack_order.size() == 2) check("to_next_owner", ack_order[1], 0);

        // tx_clear outside START is ignored
        do_reset();
        inj_clear = 1'b1;
        step();
        step();
        check("idle_clr_ack", int'(arb.ack), 0);
        check("idle_clr_idle", int'(arb.arb_idle), 1);
        check("idle_clr_grant", int'(arb.grant), 0);
        clr_max  = 0;
        busy_max = 3;
        enqueue(0, 8'h57, 1'b1);
        refresh_req();
        clear_on_ack = 1'b1;
        a0 = n_acks;
        k  = 0;
        while (n_acks == a0 && k < 50) begin step(); k++; end
        step();
        check("wait_clr_ack", int'(arb.ack), 0);
        check("wait_clr_grant", int'(arb.grant), 1);
        check("wait_clr_idle", int'(arb.arb_idle), 0);
        wait_done(100, "wait_clr_done");
        check("wait_clr_acks", n_acks - a0, 1);

        // reset during START, coinciding with tx_clear
        do_reset();
        clr_max  = 0;
        busy_max = 2;
        enqueue(1, 8'h31, 1'b1);
        refresh_req();
        wait_done(100, "mid_pre_done");
        hold_clear = 1'b1;
        enqueue(2, 8'h5A, 1'b1);
        refresh_req();
        k = 0;
        while (!arb.tx_start && k < 20) begin step(); k++; end
        check("mid_reach_start", int'(arb.tx_start), 1);
        rst          = 1'b1;
        arb.tx_clear = 1'b1;
        for (int i = 0; i < N; i++) q[i].delete();
        m_ptr  = 0;
        m_lock = -1;
        refresh_req();
        step();
        check("mid_tx_start", int'(arb.tx_start), 0);
        check("mid_grant", int'(arb.grant), 0);
        check("mid_idle", int'(arb.arb_idle), 1);
        check("mid_ack", int'(arb.ack), 0);
        rst        = 1'b0;
        hold_clear = 1'b0;
        ack_order.delete();
        enqueue(0, 8'h50, 1'b1);
        enqueue(2, 8'h51, 1'b1);
        refresh_req();
        wait_done(200, "mid_post_done");
        check("mid_post_count", ack_order.size(), 2);
        if (ack_order.size() > 0) check("mid_post_first", ack_order[0], 0);

        // randomised traffic against the queue model
        do_reset();
        for (int round = 0; round < 8; round++) begin
            clr_max  = int'($urandom_range(3));
            busy_max = int'($urandom_range(5));
            total    = 0;
            for (int i = 0; i < N; i++) begin
                nm = int'($urandom_range(2));
                for (int m = 0; m < nm; m++) begin
                    len = int'($urandom_range(3, 1));
                    for (int b = 0; b < len; b++) begin
                        enqueue(i, 8'($urandom_range(255)), b == len - 1);
                        total++;
                    end
                end
            end
            refresh_req();
            a0 = n_acks;
            wait_done(3000, "rand_done");
            check("rand_acks", n_acks - a0, total);
        end
        check("rand_no_timeout", n_timeouts, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART byte transmitter between NREQ independent requesters, for example the Wishbone CSR path, a debug/LA path and a BRAM-dump sequencer.
- Grants are round-robin, and a grant can be locked so a multi-byte message is sent without interleaving.
- The block sequences the transmitter handshake: start level, clear pulse, busy.
- It sits between the requesters and uart_transmission (or its TX FIFO front end), in the wb_clk_i domain.

Parameters:
- NREQ, 3, number of requesters (2..8).
- LOCK_TIMEOUT, 1023, idle cycles an owner may hold a locked grant before it is forcibly released.
- GUARD, 2, minimum cycles spent in WAIT before tx_busy is sampled.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req  in  NREQ  per-requester byte request (level)
- req_data  in  NREQ*8  byte for requester i, at bits [8i+7:8i]
- req_last  in  NREQ  1 = this byte ends the message (release lock); 0 = keep lock
- ack  out  NREQ  one-cycle pulse: requester i's byte was accepted by the transmitter
- grant  out  NREQ  one-hot current owner; 0 when idle
- tx_data  out  8  byte to transmitter
- tx_start  out  1  transmit request level
- tx_clear  in  1  transmitter clear-request pulse (byte taken)
- tx_busy  in  1  transmitter shifting
- arb_idle  out  1  1 in IDLE state
- timeout_evt  out  1  one-cycle pulse when a lock is forcibly released

Behaviour:
- Reset is synchronous and active-high, on rst, with clock clk.
- Reset values:
  - ack, grant, tx_data, tx_start, timeout_evt = 0.
  - arb_idle = 1.
  - Round-robin pointer = 0.
  - State = IDLE.
  - Lock flag = 0.
  - Timeout counter = 0.
- States: IDLE, LOAD, START, WAIT, HOLD.
- IDLE:
  - If req is nonzero, pick the first set bit scanning from pointer upward, with modulo-NREQ wrap.
  - Register grant as one-hot and go to LOAD next cycle.
  - Arbitration latency is 1 cycle (req seen -> grant high).
- LOAD:
  - tx_data <= owner's req_data slice.
  - Lock flag <= ~owner's req_last, both latched here.
  - Next state START; tx_start goes high at START entry.
  - The requester may change req_data after ack; it must hold req and data until ack.
- START:
  - tx_start = 1 until tx_clear is sampled high.
  - On that cycle: ack[owner] = 1, tx_start <= 0, guard counter <= 0, next state WAIT.
  - tx_clear outside START is ignored.
- WAIT:
  - The guard counter counts up to GUARD.
  - Once the counter equals GUARD and tx_busy = 0, the byte is complete.
  - If the lock flag is 0: pointer <= owner+1 (mod NREQ), grant <= 0, go to IDLE.
  - If the lock flag is 1: go to HOLD with the timeout counter at 0.
- HOLD:
  - grant stays on the owner.
  - If req[owner] = 1, go to LOAD and clear the timeout counter. Other requesters are ignored.
  - Otherwise the timeout counter increments.
  - When it reaches LOCK_TIMEOUT: timeout_evt pulse, pointer <= owner+1, grant <= 0, go to IDLE.
- The pointer advances only on release. Back-to-back requests by one unlocked owner therefore alternate with the other pending requesters.
- A requester that drops req while in LOAD/START does not abort the byte: the latched byte is still sent and ack still pulses.
- Reset mid-transfer returns to IDLE and drops tx_start in the same cycle as the rst edge. The transmitter shares the reset.
- Simultaneous tx_clear and rst: rst wins and no ack is issued.
- NREQ=1 degenerates to a pass-through with the same handshake. The pointer stays 0.
- The timeout counter width is $clog2(LOCK_TIMEOUT+1) and it saturates at LOCK_TIMEOUT.

Decomposition:
- A shared package uart_pkg holds:
  - the state encoding enum;
  - the byte width constant (8);
  - a function for rotate-priority one-hot select.
- One sub-module, uart_rr_pick: a combinational round-robin picker with inputs req and pointer, outputs one-hot and index. It is reusable for a future RX-side dispatcher.

Test Plan:
- Single request: req=3'b001, data 8'h41, last=1. Required response: grant=001 one cycle later, tx_data=8'h41 with tx_start high until the model pulses tx_clear, then ack[0] pulse, then IDLE after busy falls.
- Contention: req=3'b111 held, all last=1, data 'A','B','C'. Required response: bytes sent in order 0,1,2,0,1,2, exactly one ack per byte.
- Locked message: requester 1 sends "HI\n" with last=0,0,1 while requester 0 requests continuously. Required response: 'H','I','\n' are contiguous, then requester 0 is granted.
- Lock timeout (LOCK_TIMEOUT=15): requester 2 sends one byte with last=0, then drops req. Required response: timeout_evt 15 cycles after HOLD entry, grant=0, and requester 0 is served next.
- Ignored clear: a tx_clear pulse injected in IDLE and in WAIT produces no ack and no state change.
- Reset mid-operation: assert rst during START. Required response: tx_start=0, grant=0, arb_idle=1 on the next edge, no ack; the next request after reset is picked starting from pointer 0.
